// File: rtl/news_vend_pkg.sv
// Shared types and constants for the newspaper vending transaction controller.
// The optional seven-segment display (NEWS_VEND_SSD_EN) uses the SEG_* constants.
package news_vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_REFUND   = 3'd4
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  localparam int STAR    = 0;
  localparam int STRAITS = 1;

  // Segment order is {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Credit value of one coin code in 0.5 Rs units; invalid code counts as nothing
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] val;
    case (code)
      COIN_HALF: val = 4'd1;
      COIN_ONE:  val = 4'd2;
      default:   val = 4'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/news_ssd_dec.sv
// Combinational 4-bit value to seven-segment decoder; values above 9 are blank.
// Only instantiated when NEWS_VEND_SSD_EN is defined.
module news_ssd_dec
  import news_vend_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/news_vend_ctrl.sv
// Transaction controller for the newspaper vending machine: arbitration, coin
// collection, dispense, change/refund. NEWS_VEND_SSD_EN adds the amount-due display.
//
// state       | meaning
// ST_IDLE     | no transaction; round-robin arbitration of req_i
// ST_COLLECT  | accepting coins for the granted product, timeout running
// ST_DISPENSE | dispense/green/buzzer pulse for PULSE_CYC cycles
// ST_CHANGE   | returning surplus credit one 0.5 Rs pulse at a time
// ST_REFUND   | timeout abort: red_led pulse plus returning all credit
module news_vend_ctrl
  import news_vend_pkg::*;
#(
  parameter int PRICE_HALVES = 3,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int PULSE_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] coin_i,
  output logic [1:0] grant_o,
  output logic       coin_accept_o,
  output logic [3:0] credit_o,
  output logic [1:0] disp_o,
  output logic       green_led_o,
  output logic       buzzer_o,
  output logic       red_led_o,
  output logic       change_out_o
`ifdef NEWS_VEND_SSD_EN
  ,
  output logic [6:0] ssd_o
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYC - 1);
  localparam logic [3:0]    PRICE      = 4'(PRICE_HALVES);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [3:0]    credit_q, credit_d;
  logic          last_q, last_d;      // 1: straits served last
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          prun_q, prun_d;
  logic          phase_q, phase_d;    // 0: pulse half, 1: gap half of a change pulse
  logic [3:0]    coin_val;
  logic [3:0]    sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      credit_q <= '0;
      last_q   <= 1'b1;
      tmo_q    <= '0;
      pcnt_q   <= '0;
      prun_q   <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      pcnt_q   <= pcnt_d;
      prun_q   <= prun_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    last_d   = last_q;
    tmo_d    = tmo_q;
    pcnt_d   = pcnt_q;
    prun_d   = prun_q;
    phase_d  = phase_q;
    coin_val = coin_value(coin_i);
    sum      = credit_q + coin_val;

    // Pulse timer shared by the dispense and red_led pulses
    if (prun_q) begin
      if (pcnt_q == '0) prun_d = 1'b0;
      else              pcnt_d = pcnt_q - PW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        grant_d  = '0;
        if (req_i != 2'b00) begin
          state_d = ST_COLLECT;
          tmo_d   = TMO_LOAD;
          if (req_i == 2'b01 || (req_i == 2'b11 && last_q))
            grant_d[STAR] = 1'b1;
          else
            grant_d[STRAITS] = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (coin_val != 4'd0) begin
          tmo_d = TMO_LOAD;
          if (sum >= PRICE) begin
            credit_d = sum - PRICE;
            state_d  = ST_DISPENSE;
            pcnt_d   = PULSE_LOAD;
            prun_d   = 1'b1;
            last_d   = grant_q[STRAITS];
          end else begin
            credit_d = sum;
          end
        end else if (tmo_q == '0) begin
          if (credit_q != 4'd0) begin
            state_d = ST_REFUND;
            pcnt_d  = PULSE_LOAD;
            prun_d  = 1'b1;
            phase_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end

      ST_DISPENSE: begin
        if (pcnt_q == '0) begin
          phase_d = 1'b0;
          if (credit_q != 4'd0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end

      ST_CHANGE, ST_REFUND: begin
        // Refund also waits for the red_led pulse to finish before releasing
        if (credit_q == 4'd0) begin
          if (state_q == ST_CHANGE || !prun_q) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (!phase_q) begin
          credit_d = credit_q - 4'd1;
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_o       = grant_q;
  assign coin_accept_o = (state_q == ST_COLLECT);
  assign credit_o      = credit_q;
  assign disp_o        = (state_q == ST_DISPENSE) ? grant_q : 2'b00;
  assign green_led_o   = (state_q == ST_DISPENSE);
  assign buzzer_o      = (state_q == ST_DISPENSE);
  assign red_led_o     = (state_q == ST_REFUND) && prun_q;
  assign change_out_o  = (state_q == ST_CHANGE || state_q == ST_REFUND) &&
                         !phase_q && (credit_q != 4'd0);

`ifdef NEWS_VEND_SSD_EN
  logic [3:0] due;
  logic [6:0] seg;

  assign due = PRICE - credit_q;

  news_ssd_dec u_ssd_dec (
    .digit_i (due),
    .seg_o   (seg)
  );

  assign ssd_o = (state_q == ST_COLLECT) ? seg : SEG_BLANK;
`endif

endmodule
